// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - pseudo-random card draw and running hand totals for P1, P2 and Dealer
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       dealReq,
    input  logic [1:0] dealTarget,
    input  logic       injValid,
    input  logic [3:0] injCard,
    output logic [4:0] p1_high,
    output logic [4:0] p1_low,
    output logic [4:0] p2_high,
    output logic [4:0] p2_low,
    output logic [4:0] d_high,
    output logic [4:0] d_low,
    output logic [3:0] lastCard,
    output logic       cardsUpdated
);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, ADD = 2'd2} state_t;

    // An all-zero Fibonacci LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  target_q, target_d;
    logic [3:0]  value_q, value_d;
    logic [3:0]  last_card_q, last_card_d;
    logic [4:0]  p1_hi_q, p1_hi_d, p1_lo_q, p1_lo_d;
    logic [4:0]  p2_hi_q, p2_hi_d, p2_lo_q, p2_lo_d;
    logic [4:0]  d_hi_q, d_hi_d, d_lo_q, d_lo_d;

    logic [3:0]  sample;
    logic        sample_ok;
    logic [3:0]  sample_value;
    logic [9:0]  p1_next, p2_next, d_next;

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[5] ? 5'h1F : s[4:0];
    endfunction

    // Returns {hi, lo}; lo stays 0 until the first ace makes the soft total meaningful.
    function automatic logic [9:0] hand_add(input logic [4:0] hi, input logic [4:0] lo,
                                            input logic [3:0] v);
        if (v == 4'd1) begin
            if (lo == 5'd0) return {sat_add(hi, 5'd11), sat_add(hi, 5'd1)};
            else            return {sat_add(hi, 5'd1), sat_add(lo, 5'd1)};
        end
        return {sat_add(hi, {1'b0, v}), (lo == 5'd0) ? 5'd0 : sat_add(lo, {1'b0, v})};
    endfunction

    // Card source and rank-to-value mapping; 0 and 14..15 are rejected and redrawn.
    always_comb begin
        sample       = injValid ? injCard : lfsr_q[3:0];
        sample_ok    = (sample != 4'd0) && (sample <= 4'd13);
        sample_value = (sample > 4'd10) ? 4'd10 : sample;
        p1_next      = hand_add(p1_hi_q, p1_lo_q, value_q);
        p2_next      = hand_add(p2_hi_q, p2_lo_q, value_q);
        d_next       = hand_add(d_hi_q, d_lo_q, value_q);
    end

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_INIT;
            target_q    <= 2'd0;
            value_q     <= 4'd0;
            last_card_q <= 4'd0;
            p1_hi_q     <= 5'd0;
            p1_lo_q     <= 5'd0;
            p2_hi_q     <= 5'd0;
            p2_lo_q     <= 5'd0;
            d_hi_q      <= 5'd0;
            d_lo_q      <= 5'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            target_q    <= target_d;
            value_q     <= value_d;
            last_card_q <= last_card_d;
            p1_hi_q     <= p1_hi_d;
            p1_lo_q     <= p1_lo_d;
            p2_hi_q     <= p2_hi_d;
            p2_lo_q     <= p2_lo_d;
            d_hi_q      <= d_hi_d;
            d_lo_q      <= d_lo_d;
        end
    end

    // Next-state logic: clear aborts from anywhere, target 3 is a no-op request.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (dealReq && dealTarget != 2'd3) state_d = DRAW;
                DRAW:    if (sample_ok) state_d = ADD;
                ADD:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: LFSR free-runs, hands update only in ADD.
    always_comb begin
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        target_d    = target_q;
        value_d     = value_q;
        last_card_d = last_card_q;
        p1_hi_d     = p1_hi_q;
        p1_lo_d     = p1_lo_q;
        p2_hi_d     = p2_hi_q;
        p2_lo_d     = p2_lo_q;
        d_hi_d      = d_hi_q;
        d_lo_d      = d_lo_q;
        if (clear) begin
            last_card_d = 4'd0;
            p1_hi_d     = 5'd0;
            p1_lo_d     = 5'd0;
            p2_hi_d     = 5'd0;
            p2_lo_d     = 5'd0;
            d_hi_d      = 5'd0;
            d_lo_d      = 5'd0;
        end else begin
            case (state_q)
                IDLE: if (dealReq && dealTarget != 2'd3) target_d = dealTarget;
                DRAW: if (sample_ok) value_d = sample_value;
                ADD: begin
                    last_card_d = value_q;
                    case (target_q)
                        2'd0:    {p1_hi_d, p1_lo_d} = p1_next;
                        2'd1:    {p2_hi_d, p2_lo_d} = p2_next;
                        2'd2:    {d_hi_d, d_lo_d}   = d_next;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Outputs: totals are stable and a new request is accepted only in IDLE.
    always_comb begin
        cardsUpdated = (state_q == IDLE);
        p1_high      = p1_hi_q;
        p1_low       = p1_lo_q;
        p2_high      = p2_hi_q;
        p2_low       = p2_lo_q;
        d_high       = d_hi_q;
        d_low        = d_lo_q;
        lastCard     = last_card_q;
    end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       dealReq = 1'b0;
    logic [1:0] dealTarget = 2'd0;
    logic       injValid = 1'b0;
    logic [3:0] injCard = 4'd0;
    logic [4:0] p1_high, p1_low, p2_high, p2_low, d_high, d_low;
    logic [3:0] lastCard;
    logic       cardsUpdated;

    card_dealer dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .dealReq(dealReq),
        .dealTarget(dealTarget), .injValid(injValid), .injCard(injCard),
        .p1_high(p1_high), .p1_low(p1_low), .p2_high(p2_high), .p2_low(p2_low),
        .d_high(d_high), .d_low(d_low), .lastCard(lastCard), .cardsUpdated(cardsUpdated)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        int    p1h, p1l, p2h, p2l, dh, dl, last, lat;
        bit    full;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   prev_cu = 1'b1;
    int   low_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input int p1h, input int p1l, input int p2h,
                        input int p2l, input int dh, input int dl, input int last,
                        input int lat, input bit full);
        exp_t e;
        e.nm = nm; e.p1h = p1h; e.p1l = p1l; e.p2h = p2h; e.p2l = p2l;
        e.dh = dh; e.dl = dl; e.last = last; e.lat = lat; e.full = full;
        q.push_back(e);
    endtask

    // Injected deal: 'rej' cycles of rank 14 in DRAW, then 'card'.
    task automatic deal(input logic [1:0] tgt, input int rej, input logic [3:0] card);
        dealReq = 1'b1; dealTarget = tgt; injValid = 1'b1;
        injCard = (rej > 0) ? 4'd14 : card;
        @(posedge clk); #1 dealReq = 1'b0;
        for (int i = 0; i < rej; i++) begin
            @(posedge clk); #1;
        end
        injCard = card;
        @(posedge clk); #1;
        @(posedge clk); #1;
        injValid = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_p1h"}, p1_high, 0);
        chk({nm, "_p1l"}, p1_low, 0);
        chk({nm, "_p2h"}, p2_high, 0);
        chk({nm, "_dh"}, d_high, 0);
        chk({nm, "_last"}, lastCard, 0);
        chk({nm, "_cu"}, cardsUpdated, 1);
    endtask

    // Monitor: each rising cardsUpdated pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_cu = 1'b1;
            low_cnt = 0;
        end else begin
            if (!cardsUpdated) begin
                low_cnt++;
            end else if (!prev_cu) begin
                if (q.size() == 0) begin
                    chk("unexpected_update", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (e.full) begin
                        chk({e.nm, "_p1h"}, p1_high, e.p1h);
                        chk({e.nm, "_p1l"}, p1_low, e.p1l);
                        chk({e.nm, "_p2h"}, p2_high, e.p2h);
                        chk({e.nm, "_p2l"}, p2_low, e.p2l);
                        chk({e.nm, "_dh"}, d_high, e.dh);
                        chk({e.nm, "_dl"}, d_low, e.dl);
                        chk({e.nm, "_last"}, lastCard, e.last);
                    end else begin
                        chk({e.nm, "_last_in_range"},
                            int'(lastCard >= 4'd1 && lastCard <= 4'd10), 1);
                    end
                    if (e.lat > 0) chk({e.nm, "_latency"}, low_cnt, e.lat);
                end
                low_cnt = 0;
            end
            prev_cu = cardsUpdated;
        end
    end

    initial begin
        int cnt;
        #2 check_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // P1: 7 then 9
        push("p1_7", 7, 0, 0, 0, 0, 0, 7, 2, 1);
        deal(2'd0, 0, 4'd7);
        push("p1_9", 16, 0, 0, 0, 0, 0, 9, 2, 1);
        deal(2'd0, 0, 4'd9);

        // P2: 5, ace, ace, king
        push("p2_5", 16, 0, 5, 0, 0, 0, 5, 2, 1);
        deal(2'd1, 0, 4'd5);
        push("p2_ace1", 16, 0, 16, 6, 0, 0, 1, 2, 1);
        deal(2'd1, 0, 4'd1);
        push("p2_ace2", 16, 0, 17, 7, 0, 0, 1, 2, 1);
        deal(2'd1, 0, 4'd1);
        push("p2_king", 16, 0, 27, 17, 0, 0, 10, 2, 1);
        deal(2'd1, 0, 4'd13);

        // Dealer: three rejects then 4
        push("d_reject", 16, 0, 27, 17, 4, 0, 4, 5, 1);
        deal(2'd2, 3, 4'd4);

        // Clear, then saturate P1
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        check_zero("clear_idle");
        push("p1_10a", 10, 0, 0, 0, 0, 0, 10, 2, 1);
        deal(2'd0, 0, 4'd10);
        push("p1_10b", 20, 0, 0, 0, 0, 0, 10, 2, 1);
        deal(2'd0, 0, 4'd10);
        push("p1_10c", 30, 0, 0, 0, 0, 0, 10, 2, 1);
        deal(2'd0, 0, 4'd10);
        push("p1_sat", 31, 0, 0, 0, 0, 0, 10, 2, 1);
        deal(2'd0, 0, 4'd10);
        push("p1_ace_sat", 31, 31, 0, 0, 0, 0, 1, 2, 1);
        deal(2'd0, 0, 4'd1);

        // Reserved target
        dealReq = 1'b1; dealTarget = 2'd3; injValid = 1'b1; injCard = 4'd5;
        @(posedge clk); #1 dealReq = 1'b0;
        chk("tgt3_cu", cardsUpdated, 1);
        @(posedge clk); #1;
        chk("tgt3_cu2", cardsUpdated, 1);
        chk("tgt3_p1h", p1_high, 31);
        injValid = 1'b0;

        // clear together with dealReq
        clear = 1'b1; dealReq = 1'b1; dealTarget = 2'd0; injValid = 1'b1; injCard = 4'd5;
        @(posedge clk); #1 clear = 1'b0; dealReq = 1'b0;
        check_zero("clear_deal");
        @(posedge clk); #1;
        chk("clear_deal_dropped_cu", cardsUpdated, 1);
        chk("clear_deal_dropped_p1h", p1_high, 0);
        injValid = 1'b0;

        // clear during DRAW
        push("p2_8", 0, 0, 8, 0, 0, 0, 8, 2, 1);
        deal(2'd1, 0, 4'd8);
        push("clear_draw", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        dealReq = 1'b1; dealTarget = 2'd2; injValid = 1'b1; injCard = 4'd14;
        @(posedge clk); #1 dealReq = 1'b0; clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0; injValid = 1'b0;
        @(posedge clk); #1;
        chk("clear_draw_idle_cu", cardsUpdated, 1);
        chk("clear_draw_dh", d_high, 0);

        // Free-running LFSR deals
        for (int i = 0; i < 1000; i++) begin
            push("freerun", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            dealReq = 1'b1; dealTarget = 2'(i % 3);
            @(posedge clk); #1 dealReq = 1'b0;
            cnt = 0;
            while (!cardsUpdated && cnt < 100) begin
                @(posedge clk); #1;
                cnt++;
            end
            if (!cardsUpdated) begin
                chk("freerun_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;

        // Asynchronous reset mid-DRAW
        dealReq = 1'b1; dealTarget = 2'd0; injValid = 1'b1; injCard = 4'd14;
        @(posedge clk); #1 dealReq = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_in_draw", cardsUpdated, 0);
        rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b1; injValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
